conf_chain_loader: RTL and testbench

//  Drives the serial config latch chain, the far end of the CONFin/CONFout path through tile BELs.
//  - Accepts config words from a host over valid/ready.
//  - Serializes each word onto CONF_D.
//  - Generates two non-overlapping latch-enable phases:
//    - PH1 drives the chain's CLK-side latch enables.
//    - PH2 drives the chain's MODE-side latch enables.
//  - Sits between the bitstream host interface and the first tile's CONFin; CONF_Q returns from the last CONFout.

---
 rtl/conf_loader_pkg.sv | 24 ++
 rtl/conf_phase_gen.sv | 49 ++++
 rtl/conf_chain_loader.sv | 159 +++++++++++++++
 tb/tb_conf_chain_loader.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conf_loader_pkg.sv
// Shared encodings and frame-geometry helper for the config chain loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package conf_loader_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        SHIFT     = 2'd2,
        FIN       = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PH_D  = 2'd0,
        PH_P1 = 2'd1,
        PH_G  = 2'd2,
        PH_P2 = 2'd3
    } phase_t;

    function automatic int words_per_frame(input int chain_len, input int data_w);
        return (chain_len + data_w - 1) / data_w;
    endfunction

endpackage

// File: rtl/conf_phase_gen.sv
// Four-cycle D/P1/G/P2 sub-phase sequencer with registered latch-enable phases.
// Latency: PH1 one cycle after D, PH2 one cycle after G; bit_done is combinational in P2.
// Backpressure: none; run_i low parks the counter in D with both phases low.
module conf_phase_gen
    import conf_loader_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   run_i,
    output phase_t phase_o,
    output logic   ph1_o,
    output logic   ph2_o,
    output logic   bit_done_o
);

    phase_t cnt_q, cnt_d;
    logic   ph1_q, ph1_d;
    logic   ph2_q, ph2_d;

    // Phases are decoded one sub-phase early so they leave a flop, never a decoder.
    always_comb begin
        cnt_d = PH_D;
        ph1_d = 1'b0;
        ph2_d = 1'b0;
        if (run_i) begin
            cnt_d = phase_t'(cnt_q + 2'd1);
            ph1_d = (cnt_q == PH_D);
            ph2_d = (cnt_q == PH_G);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= PH_D;
            ph1_q <= 1'b0;
            ph2_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ph1_q <= ph1_d;
            ph2_q <= ph2_d;
        end
    end

    assign phase_o    = cnt_q;
    assign ph1_o      = ph1_q;
    assign ph2_o      = ph2_q;
    assign bit_done_o = run_i && (cnt_q == PH_P2);

endmodule

// File: rtl/conf_chain_loader.sv
// Serial config-chain loader: host words in over valid/ready, MSB-first bits out with PH1/PH2 latch enables.
// Latency: 4 cycles per bit plus one WAIT_WORD cycle per word; DONE pulses one cycle after the last PH2.
// Backpressure: WORD_READY only in WAIT_WORD; host stalls park the chain. Readback via CONF_READBACK_EN.
module conf_chain_loader
    import conf_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int DATA_W    = 32
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              START,
    input  logic [DATA_W-1:0] WORD_DATA,
    input  logic              WORD_VALID,
    output logic              WORD_READY,
    output logic              BUSY,
    output logic              DONE,
    output logic              CONF_D,
    output logic              CONF_PH1,
    output logic              CONF_PH2,
    input  logic              CONF_Q
`ifdef CONF_READBACK_EN
    ,
    output logic [DATA_W-1:0] RB_DATA,
    output logic              RB_VALID
`endif
);

    localparam int WORDS  = words_per_frame(CHAIN_LEN, DATA_W);
    localparam int LAST_N = CHAIN_LEN - (WORDS - 1) * DATA_W;
    localparam int FW     = $clog2(CHAIN_LEN + 1);
    localparam int WW     = $clog2(DATA_W + 1);

    state_t            state_q, state_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic [WW-1:0]     wcnt_q, wcnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;

    logic   in_shift, accept, word_end, frame_end;
    logic   bit_done, ph1, ph2;
    phase_t phase;

    assign in_shift  = (state_q == SHIFT);
    assign accept    = (state_q == WAIT_WORD) && WORD_VALID;
    assign word_end  = bit_done && (wcnt_q == WW'(1));
    assign frame_end = word_end && (fcnt_q == FW'(1));

    conf_phase_gen u_phase (
        .clk_i      (CLK),
        .rst_ni     (RESETn),
        .run_i      (in_shift),
        .phase_o    (phase),
        .ph1_o      (ph1),
        .ph2_o      (ph2),
        .bit_done_o (bit_done)
    );

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (START) state_d = WAIT_WORD;
            WAIT_WORD: if (WORD_VALID) state_d = SHIFT;
            SHIFT:     if (word_end) state_d = frame_end ? FIN : WAIT_WORD;
            FIN:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        WORD_READY = 1'b0;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        case (state_q)
            WAIT_WORD: begin
                WORD_READY = 1'b1;
                BUSY       = 1'b1;
            end
            SHIFT:   BUSY = 1'b1;
            FIN:     DONE = 1'b1;
            default: ;
        endcase
    end

    assign CONF_D   = in_shift & sh_q[DATA_W-1];
    assign CONF_PH1 = ph1;
    assign CONF_PH2 = ph2;

    // Only the last word of a frame ever sees exactly LAST_N bits still outstanding.
    always_comb begin
        fcnt_d = fcnt_q;
        wcnt_d = wcnt_q;
        sh_d   = sh_q;
        if ((state_q == IDLE) && START) fcnt_d = FW'(CHAIN_LEN);
        if (accept) begin
            sh_d   = WORD_DATA;
            wcnt_d = (fcnt_q == FW'(LAST_N)) ? WW'(LAST_N) : WW'(DATA_W);
        end
        if (bit_done) begin
            sh_d   = {sh_q[DATA_W-2:0], 1'b0};
            wcnt_d = wcnt_q - WW'(1);
            fcnt_d = fcnt_q - FW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            fcnt_q <= '0;
            wcnt_q <= '0;
            sh_q   <= '0;
        end else begin
            fcnt_q <= fcnt_d;
            wcnt_q <= wcnt_d;
            sh_q   <= sh_d;
        end
    end

`ifdef CONF_READBACK_EN
    logic [DATA_W-1:0] rb_sh_q, rb_sh_d;
    logic [DATA_W-1:0] rb_dat_q, rb_dat_d;
    logic              rb_vld_q, rb_vld_d;

    // CONF_Q is settled during D, so a partial word lands right-aligned.
    always_comb begin
        rb_sh_d  = rb_sh_q;
        rb_dat_d = rb_dat_q;
        rb_vld_d = 1'b0;
        if (accept) rb_sh_d = '0;
        else if (in_shift && (phase == PH_D)) rb_sh_d = {rb_sh_q[DATA_W-2:0], CONF_Q};
        if (word_end) begin
            rb_dat_d = rb_sh_q;
            rb_vld_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rb_sh_q  <= '0;
            rb_dat_q <= '0;
            rb_vld_q <= 1'b0;
        end else begin
            rb_sh_q  <= rb_sh_d;
            rb_dat_q <= rb_dat_d;
            rb_vld_q <= rb_vld_d;
        end
    end

    assign RB_DATA  = rb_dat_q;
    assign RB_VALID = rb_vld_q;
`else
    logic unused_conf_q;
    assign unused_conf_q = CONF_Q ^ (phase == PH_D);
`endif

endmodule

// File: tb/tb_conf_chain_loader.sv
// Bench for conf_chain_loader: a 64-bit and a 40-bit chain, each driving a two-phase latch-pair chain model.
module tb_conf_chain_loader;

    logic        clk;
    logic        rst_n;
    logic        start [2];
    logic        valid [2];
    logic [31:0] wdata [2];
    logic        ready [2];
    logic        busy  [2];
    logic        done  [2];
    logic        cd    [2];
    logic        p1    [2];
    logic        p2    [2];
    logic        q     [2];
`ifdef CONF_READBACK_EN
    logic [31:0] rbd [2];
    logic        rbv [2];
`endif

    conf_chain_loader #(.CHAIN_LEN(64), .DATA_W(32)) u_dut64 (
        .CLK(clk), .RESETn(rst_n), .START(start[0]), .WORD_DATA(wdata[0]),
        .WORD_VALID(valid[0]), .WORD_READY(ready[0]), .BUSY(busy[0]), .DONE(done[0]),
        .CONF_D(cd[0]), .CONF_PH1(p1[0]), .CONF_PH2(p2[0]), .CONF_Q(q[0])
`ifdef CONF_READBACK_EN
        , .RB_DATA(rbd[0]), .RB_VALID(rbv[0])
`endif
    );

    conf_chain_loader #(.CHAIN_LEN(40), .DATA_W(32)) u_dut40 (
        .CLK(clk), .RESETn(rst_n), .START(start[1]), .WORD_DATA(wdata[1]),
        .WORD_VALID(valid[1]), .WORD_READY(ready[1]), .BUSY(busy[1]), .DONE(done[1]),
        .CONF_D(cd[1]), .CONF_PH1(p1[1]), .CONF_PH2(p2[1]), .CONF_Q(q[1])
`ifdef CONF_READBACK_EN
        , .RB_DATA(rbd[1]), .RB_VALID(rbv[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // Latch-pair chain model: PH1 loads masters from the upstream slave, PH2 copies master to slave.
    logic [63:0] mst [2];
    logic [63:0] slv [2];
    logic        preload [2];
    logic [63:0] pre_val;

    function automatic logic [63:0] mask_of(input int i);
        return (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_00FF_FFFF_FFFF;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (preload[i]) begin
                mst[i] <= pre_val;
                slv[i] <= pre_val;
            end else begin
                if (p1[i]) mst[i] <= ((slv[i] << 1) | {63'd0, cd[i]}) & mask_of(i);
                if (p2[i]) slv[i] <= mst[i];
            end
        end
    end

    assign q[0] = slv[0][63];
    assign q[1] = slv[1][39];

    // Per-instance event monitors.
    int          done_cnt [2];
    int          done_cyc [2];
    int          ovl_cnt  [2];
    int          dstab    [2];
    int          hold_k   [2];
    logic        hold_d   [2];
    logic        prev_d   [2];
    int          rb_cnt   [2];
    logic [31:0] rb_w     [2][16];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (done[i]) begin
                done_cnt[i] <= done_cnt[i] + 1;
                done_cyc[i] <= cyc;
            end
            if (p1[i] && p2[i]) ovl_cnt[i] <= ovl_cnt[i] + 1;
            if (p1[i]) begin
                if (cd[i] !== prev_d[i]) dstab[i] <= dstab[i] + 1;
                hold_d[i] <= cd[i];
                hold_k[i] <= 2;
            end else if (hold_k[i] > 0) begin
                if (cd[i] !== hold_d[i]) dstab[i] <= dstab[i] + 1;
                hold_k[i] <= hold_k[i] - 1;
            end
            prev_d[i] <= cd[i];
`ifdef CONF_READBACK_EN
            if (rbv[i]) begin
                if (rb_cnt[i] < 16) rb_w[i][rb_cnt[i]] <= rbd[i];
                rb_cnt[i] <= rb_cnt[i] + 1;
            end
`endif
        end
    end

    int n_chk;
    int n_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: timed out, got no event expected one", name);
    endtask

    task automatic wait_accept(input int i, input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            got = ready[i];
            @(posedge clk);
            #1;
            if (got) break;
        end
        if (!got) timeout(name);
    endtask

    typedef struct {
        int          inst;
        logic [63:0] pre;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          stall;
        logic [63:0] exp_chain;
        int          exp_lat;
        logic [31:0] exp_rb0;
        logic [31:0] exp_rb1;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input int vi, input vec_t v);
        int  i, c0, d0, o0, s0, r0, bad;
        logic [63:0] snap;
        logic seen;
        i = v.inst;
        @(posedge clk);
        #1;
        pre_val    = v.pre;
        preload[i] = 1'b1;
        @(posedge clk);
        #1;
        preload[i] = 1'b0;
        d0 = done_cnt[i];
        o0 = ovl_cnt[i];
        s0 = dstab[i];
        r0 = rb_cnt[i];
        c0 = cyc;
        start[i] = 1'b1;
        valid[i] = 1'b1;
        wdata[i] = v.w0;
        @(posedge clk);
        #1;
        start[i] = 1'b0;
        wait_accept(i, $sformatf("v%0d_accept0", vi));
        if (v.stall) begin
            valid[i] = 1'b0;
            wdata[i] = 32'h0;
            seen = 1'b0;
            for (int k = 0; k < 300; k++) begin
                @(negedge clk);
                if (ready[i]) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) timeout($sformatf("v%0d_stall_ready", vi));
            snap = slv[i];
            bad  = 0;
            for (int k = 0; k < 10; k++) begin
                if ({busy[i], ready[i], p1[i], p2[i]} !== 4'b1100) bad++;
                @(posedge clk);
                #1;
                start[i] = (k == 3);
                if (k < 9) @(negedge clk);
            end
            start[i] = 1'b0;
            chk($sformatf("v%0d_stall_idle_cycles", vi), 64'(bad), 64'd0);
            chk($sformatf("v%0d_stall_chain_hold", vi), slv[i], snap);
        end
        valid[i] = 1'b1;
        wdata[i] = v.w1;
        wait_accept(i, $sformatf("v%0d_accept1", vi));
        valid[i] = 1'b0;
        wdata[i] = 32'h0;
        seen = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (done[i]) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeout($sformatf("v%0d_done", vi));
        chk($sformatf("v%0d_busy_at_done", vi), 64'(busy[i]), 64'd0);
        if (v.stall) begin
            start[i] = 1'b1;
            @(posedge clk);
            #1;
            start[i] = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_start_at_done_ignored", vi), 64'(busy[i]), 64'd0);
        end
        repeat (6) @(negedge clk);
        chk($sformatf("v%0d_latency", vi), 64'(done_cyc[i] - c0), 64'(v.exp_lat));
        chk($sformatf("v%0d_done_count", vi), 64'(done_cnt[i] - d0), 64'd1);
        chk($sformatf("v%0d_phase_overlap", vi), 64'(ovl_cnt[i] - o0), 64'd0);
        chk($sformatf("v%0d_d_stable", vi), 64'(dstab[i] - s0), 64'd0);
        chk($sformatf("v%0d_chain", vi), slv[i], v.exp_chain);
`ifdef CONF_READBACK_EN
        chk($sformatf("v%0d_rb_count", vi), 64'(rb_cnt[i] - r0), 64'd2);
        if (r0 + 1 < 16) begin
            chk($sformatf("v%0d_rb_word0", vi), 64'(rb_w[i][r0]), 64'(v.exp_rb0));
            chk($sformatf("v%0d_rb_word1", vi), 64'(rb_w[i][r0 + 1]), 64'(v.exp_rb1));
        end
`else
        if (r0 != rb_cnt[i]) $display("readback strobes without readback build");
`endif
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        vecs[0] = '{0, 64'hCAFEF00D_12345678, 32'hDEADBEEF, 32'h0123ABCD, 1'b0,
                    64'hDEADBEEF_0123ABCD, 259, 32'hCAFEF00D, 32'h12345678};
        vecs[1] = '{0, 64'hFFFF0000_0000FFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0,
                    64'h00000000_FFFFFFFF, 259, 32'hFFFF0000, 32'h0000FFFF};
        vecs[2] = '{0, 64'h01234567_89ABCDEF, 32'h80000001, 32'h55AA55AA, 1'b1,
                    64'h80000001_55AA55AA, 269, 32'h01234567, 32'h89ABCDEF};
        vecs[3] = '{1, 64'h000000C3_5A5A5A5A, 32'hFFFFFFFF, 32'hA5000000, 1'b0,
                    64'h000000FF_FFFFFFA5, 163, 32'hC35A5A5A, 32'h0000005A};
        vecs[4] = '{1, 64'h000000FE_DCBA9876, 32'h12345678, 32'h9AFFFFFF, 1'b0,
                    64'h00000012_3456789A, 163, 32'hFEDCBA98, 32'h00000076};
        vecs[5] = '{1, 64'h000000AA_AAAAAAAA, 32'h00000000, 32'hFF123456, 1'b1,
                    64'h00000000_000000FF, 173, 32'hAAAAAAAA, 32'h000000AA};

        rst_n   = 1'b0;
        pre_val = 64'h0;
        for (int i = 0; i < 2; i++) begin
            start[i]   = 1'b0;
            valid[i]   = 1'b0;
            wdata[i]   = 32'h0;
            preload[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) preload[i] = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_outputs_64", {58'd0, busy[0], ready[0], done[0], p1[0], p2[0], cd[0]}, 64'd0);
        chk("idle_outputs_40", {58'd0, busy[1], ready[1], done[1], p1[1], p2[1], cd[1]}, 64'd0);

        // Abort a frame with reset while PH1 is high and CONF_D carries a 1.
        start[0] = 1'b1;
        valid[0] = 1'b1;
        wdata[0] = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (p1[0]) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) timeout("reset_reach_p1");
        end
        chk("pre_reset_active", {61'd0, p1[0], cd[0], busy[0]}, 64'd7);
        rst_n = 1'b0;
        #1;
        chk("reset_async_outputs", {59'd0, p1[0], p2[0], cd[0], busy[0], ready[0]}, 64'd0);
        valid[0] = 1'b0;
        wdata[0] = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_release_idle", {60'd0, busy[0], ready[0], done[0], p1[0]}, 64'd0);

        for (int v = 0; v < 6; v++) run_vec(v, vecs[v]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
